// File: rtl/zip_reduce_n_pkg.sv
// Shared encodings for the N-stream zip/reduce block: reduction modes, FSM states
// and a constant-safe ceil(log2) helper.
package zip_reduce_n_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_WRAP = 2'd0,
        MODE_ADD_SAT  = 2'd1,
        MODE_MIN      = 2'd2,
        MODE_MAX      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/zip_reduce_n_stream_fifo.sv
// Registered synchronous FIFO for one input stream; pointers carry an extra wrap
// bit so full/empty come straight from the pointers (DEPTH must be a power of 2).
module stream_fifo
    import zip_reduce_n_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_valid,
    input  logic [W-1:0] data_in,
    output logic         push_ready,
    input  logic         pop,
    output logic [W-1:0] data_out,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         push;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Readiness depends on occupancy only, so a same-cycle pop never frees a slot.
    assign push_ready = !full;
    assign push       = push_valid && !full;
    assign data_out   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)          wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/zip_reduce_n.sv
// Joins N valid/ready streams elementwise through per-stream FIFOs and reduces each
// joined set (wrap add, saturating add, signed min/max) into a registered result.
module zip_reduce_n
    import zip_reduce_n_pkg::*;
#(
    parameter int N     = 3,
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [N*W-1:0]   sIn,
    input  logic [N-1:0]     sIn_valid,
    output logic [N-1:0]     sIn_ready,
    output logic [W-1:0]     sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready
);

    localparam int SUM_W = W + clog2(N);
    localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};

    state_e                   state;
    mode_e                    mode_q;
    logic [CNT_W-1:0]         len_q;
    logic [CNT_W-1:0]         count;
    logic [N-1:0]             empty_v;
    logic signed [W-1:0]      head [N];
    logic                     fire;
    logic signed [SUM_W-1:0]  sum_p0;
    logic signed [W-1:0]      min_p0;
    logic signed [W-1:0]      max_p0;
    logic signed [W-1:0]      red_p0;
    logic                     unused_out_ready;

    assign unused_out_ready = out_ready;

    function automatic logic signed [W-1:0] sat_w(input logic signed [SUM_W-1:0] s);
        if (s > SAT_HI)      return SAT_HI[W-1:0];
        else if (s < SAT_LO) return SAT_LO[W-1:0];
        else                 return s[W-1:0];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_fifo
        stream_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .nrst       (nrst),
            .push_valid (sIn_valid[g]),
            .data_in    (sIn[g*W +: W]),
            .push_ready (sIn_ready[g]),
            .pop        (fire),
            .data_out   (head[g]),
            .empty      (empty_v[g])
        );
    end

    assign in_ready = (state == ST_IDLE);
    assign fire     = (state == ST_RUN) && !(|empty_v) && (!sOut_valid || sOut_ready);

    // Stage p0: combinational reduce of the FIFO heads, registered into sOut on fire
    always_comb begin
        sum_p0 = '0;
        min_p0 = head[0];
        max_p0 = head[0];
        for (int i = 0; i < N; i++) begin
            sum_p0 = sum_p0 + SUM_W'(head[i]);
            if (head[i] < min_p0) min_p0 = head[i];
            if (head[i] > max_p0) max_p0 = head[i];
        end
        case (mode_q)
            MODE_ADD_WRAP: red_p0 = sum_p0[W-1:0];
            MODE_ADD_SAT:  red_p0 = sat_w(sum_p0);
            MODE_MIN:      red_p0 = min_p0;
            default:       red_p0 = max_p0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_ADD_WRAP;
            len_q      <= '0;
            count      <= '0;
            sOut       <= '0;
            sOut_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (fire) begin
                sOut       <= red_p0;
                sOut_valid <= 1'b1;
            end else if (sOut_ready) begin
                sOut_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state  <= ST_RUN;
                        mode_q <= mode_e'(mode);
                        len_q  <= len;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        count <= count + CNT_W'(1);
                        // len==0 means unbounded: never leaves RUN
                        if (len_q != '0 && count == len_q - CNT_W'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sOut_valid && sOut_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zip_reduce_n.sv
// Directed bench for zip_reduce_n (N=3, W=8, DEPTH=4) with a queue-based reference
// model compared every cycle, plus hand-computed expected results per test.
module tb_zip_reduce_n;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [CNT_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   sIn;
    logic [N-1:0]     sIn_valid;
    logic [N-1:0]     sIn_ready;
    logic [W-1:0]     sOut;
    logic             sOut_valid;
    logic             sOut_ready;

    always #5 clk = ~clk;

    zip_reduce_n #(.N(N), .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .len        (len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sIn        (sIn),
        .sIn_valid  (sIn_valid),
        .sIn_ready  (sIn_ready),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready)
    );

    int checks = 0;
    int passed = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // ---------------- reference model ----------------
    int q [N][$];
    int m_state, m_mode, m_len, m_cnt, m_out;
    bit m_vld, m_pulse;
    bit m_fire, m_old_vld, m_all_ne;
    bit [N-1:0] m_acc;
    int m_h [N];
    int m_v;

    function automatic int model_reduce(input int a, input int b, input int c, input int md);
        int s, r;
        s = a + b + c;
        case (md)
            0: r = s;
            1: r = (s > 127) ? 127 : ((s < -128) ? -128 : s);
            2: begin r = (a < b) ? a : b; r = (c < r) ? c : r; end
            default: begin r = (a > b) ? a : b; r = (c > r) ? c : r; end
        endcase
        return r & 255;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_state = 0; m_mode = 0; m_len = 0; m_cnt = 0;
            m_out = 0; m_vld = 0; m_pulse = 0;
        end else begin
            m_old_vld = m_vld;
            m_all_ne  = 1;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0) m_all_ne = 0;
                m_acc[i] = sIn_valid[i] && (q[i].size() < DEPTH);
            end
            m_fire  = (m_state == 1) && m_all_ne && (!m_vld || sOut_ready);
            m_pulse = 0;
            if (m_fire) begin
                for (int i = 0; i < N; i++) m_h[i] = q[i].pop_front();
                m_out = model_reduce(m_h[0], m_h[1], m_h[2], m_mode);
                m_vld = 1;
                m_cnt++;
            end else if (sOut_ready) begin
                m_vld = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    m_v = $signed(sIn[i*W +: W]);
                    q[i].push_back(m_v);
                end
            end
            case (m_state)
                0: if (in_valid) begin m_state = 1; m_mode = mode; m_len = len; m_cnt = 0; end
                1: if (m_fire && m_len != 0 && m_cnt == m_len) m_state = 2;
                default: if (m_old_vld && sOut_ready) begin m_state = 0; m_pulse = 1; end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    int got [$];
    int pulses = 0;
    bit t5_on = 0;
    bit prev_v = 0;
    int viol = 0;
    int exp_rdy;

    always @(negedge clk) begin
        if (nrst && cmp_en) begin
            exp_rdy = 0;
            for (int i = 0; i < N; i++) if (q[i].size() < DEPTH) exp_rdy = exp_rdy | (1 << i);
            chk("sOut_valid", int'(sOut_valid), int'(m_vld));
            chk("sOut", int'(sOut), m_out);
            chk("in_ready", int'(in_ready), int'(m_state == 0));
            chk("sIn_ready", int'(sIn_ready), exp_rdy);
            chk("out_valid", int'(out_valid), int'(m_pulse));
            if (sOut_valid && sOut_ready) got.push_back(int'(sOut));
            if (out_valid) pulses++;
            if (t5_on && sOut_valid && prev_v) viol++;
            prev_v = sOut_valid;
        end
    end

    // ---------------- stream sources ----------------
    int src_q [N][$];
    bit alt [N];
    bit tog = 0;
    int dv;

    initial begin
        sIn_valid = '0;
        sIn = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (sIn_valid[i] && sIn_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            tog = ~tog;
            #1;
            for (int i = 0; i < N; i++) begin
                if (nrst && src_q[i].size() > 0 && (!alt[i] || tog)) begin
                    dv = src_q[i][0];
                    sIn[i*W +: W] = dv[W-1:0];
                    sIn_valid[i] = 1'b1;
                end else begin
                    sIn_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic start_run(input int md, input int ln);
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode = md[1:0];
        len = ln[CNT_W-1:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk({name, "_done_in_budget"}, int'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic expect_got(input string name, input int exp [$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            chk($sformatf("%s_elem%0d", name, k), got[k], exp[k]);
        got.delete();
    endtask

    task automatic one_shot(input string name, input int md, input int a, input int b, input int c, input int exp);
        got.delete();
        src_q[0].push_back(a);
        src_q[1].push_back(b);
        src_q[2].push_back(c);
        start_run(md, 1);
        wait_done(name, 30);
        chk(name, (got.size() == 1) ? got[0] : -1, exp);
        got.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        in_valid = 0; mode = 0; len = 0; out_ready = 1; sOut_ready = 1;
        for (int i = 0; i < N; i++) alt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_sIn_ready", int'(sIn_ready), 7);
        chk("rst_sOut_valid", int'(sOut_valid), 0);
        chk("rst_sOut", int'(sOut), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        nrst = 1;
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;

        // T1: wrap add, len 4
        got.delete(); pulses = 0;
        src_q[0] = '{1, 2, 3, 4};
        src_q[1] = '{2, 4, 6, 8};
        src_q[2] = '{0, 0, 0, 1};
        start_run(0, 4);
        wait_done("t1", 50);
        repeat (2) @(posedge clk);
        #1;
        expect_got("t1", '{3, 6, 9, 13});
        chk("t1_pulses", pulses, 1);
        chk("t1_in_ready", int'(in_ready), 1);

        // T2 / T3: arithmetic corners
        one_shot("t2_wrap", 0, 100, 100, 100, 44);
        one_shot("t2_sat_pos", 1, 100, 100, 100, 127);
        one_shot("t2_sat_neg", 1, -100, -100, -100, 128);
        one_shot("t2_sat_mid", 1, 100, 100, -100, 100);
        one_shot("t3_min", 2, 5, -3, 7, 253);
        one_shot("t3_max", 3, 5, -3, 7, 7);
        one_shot("t3_max_neg", 3, -128, -1, -5, 255);

        // T4: output back-pressure fills every FIFO
        got.delete();
        sOut_ready = 0;
        src_q[0] = '{1, 2, 3, 4, 5, 6, 7, 8};
        src_q[1] = '{2, 4, 6, 8, 10, 12, 14, 16};
        src_q[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
        start_run(0, 8);
        repeat (10) @(negedge clk);
        chk("t4_hold_valid", int'(sOut_valid), 1);
        chk("t4_hold_value", int'(sOut), 3);
        chk("t4_sIn_ready_full", int'(sIn_ready), 0);
        @(posedge clk); #1;
        sOut_ready = 1;
        wait_done("t4", 60);
        expect_got("t4", '{3, 6, 9, 12, 15, 18, 21, 24});

        // T5: stream B valid every other cycle
        got.delete();
        alt[1] = 1;
        viol = 0;
        start_run(0, 6);
        src_q[0] = '{1, 2, 3, 4, 5, 6};
        src_q[1] = '{1, 2, 3, 4, 5, 6};
        src_q[2] = '{1, 2, 3, 4, 5, 6};
        t5_on = 1;
        wait_done("t5", 80);
        t5_on = 0;
        alt[1] = 0;
        expect_got("t5", '{3, 6, 9, 12, 15, 18});
        chk("t5_back_to_back", viol, 0);

        // T6: reset in the middle of an unbounded run
        sOut_ready = 0;
        for (int k = 0; k < 10; k++) begin
            src_q[0].push_back(k);
            src_q[1].push_back(k);
            src_q[2].push_back(k);
        end
        start_run(0, 0);
        repeat (4) @(posedge clk);
        #3;
        chk("t6_busy", int'(sOut_valid), 1);
        chk("t6_busy_sIn_ready", int'(sIn_ready), 0);
        nrst = 0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        #1;
        chk("t6_rst_sOut_valid", int'(sOut_valid), 0);
        chk("t6_rst_sOut", int'(sOut), 0);
        chk("t6_rst_in_ready", int'(in_ready), 1);
        chk("t6_rst_sIn_ready", int'(sIn_ready), 7);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        pulses = 0;
        got.delete();
        sOut_ready = 1;
        nrst = 1;
        repeat (6) @(negedge clk);
        chk("t6_no_pulse", pulses, 0);
        chk("t6_no_stale", got.size(), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_sIn_ready", int'(sIn_ready), 7);
        chk("t6_sOut_valid", int'(sOut_valid), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
